// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch and data access.
// Only one transaction is in flight at a time. The data side has priority,
// but a pending fetch is guaranteed a grant after STARVE consecutive data
// grants.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | port free; arbitrate, grant combinationally, stores finish here
//   WAIT   | read in flight; lat_cnt counts down, owner's rvalid at count 1
//
// Outputs are forced to zero while reset is high, so that a request seen
// during reset never reaches the memory as a write.
module mem_port_arbiter #(
   parameter int AW     = 64,
   parameter int DW     = 64,
   parameter int LAT    = 1,
   parameter int STARVE = 4
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [31:0]   i_rdata,

   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,

   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata,

   output logic          busy
);

   localparam int LCW = (LAT > 1) ? $clog2(LAT + 1) : 1;
   localparam int SCW = (STARVE > 1) ? $clog2(STARVE + 1) : 1;

   localparam logic [LCW-1:0] LAT_INIT   = LCW'(LAT);
   localparam logic [LCW-1:0] LAT_LAST   = LCW'(1);
   localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t           state_q,      state_d;
   logic [LCW-1:0]   lat_cnt_q,    lat_cnt_d;
   logic [SCW-1:0]   starve_cnt_q, starve_cnt_d;
   logic [AW-1:0]    addr_q,       addr_d;
   logic             own_data_q,   own_data_d;   // 1: data side owns the read
   logic             we_q,         we_d;

   logic             fetch_forced;
   logic             d_wins;
   logic             i_wins;

   // Winner selection: the fetch side wins a collision only once the data
   // side has used up its allowance of consecutive grants.
   always_comb begin
      fetch_forced = i_req && (starve_cnt_q == STARVE_MAX);
      d_wins       = d_req && !fetch_forced;
      i_wins       = i_req && !d_wins;
   end

   // Next-state, counters and all port outputs.
   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      addr_d       = addr_q;
      own_data_d   = own_data_q;
      we_d         = we_q;

      i_gnt        = 1'b0;
      i_rvalid     = 1'b0;
      i_rdata      = '0;
      d_gnt        = 1'b0;
      d_rvalid     = 1'b0;
      d_rdata      = '0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_wr       = 1'b0;
      busy         = 1'b0;

      if (!reset) begin
         unique case (state_q)
            S_IDLE: begin
               if (d_wins) begin
                  d_gnt      = 1'b1;
                  mem_addr   = d_addr;
                  addr_d     = d_addr;
                  own_data_d = 1'b1;
                  we_d       = d_we;
                  if (d_we) begin
                     // Store completes in the grant cycle; port stays free.
                     mem_wr    = 1'b1;
                     mem_wdata = d_wdata;
                  end else begin
                     state_d   = S_WAIT;
                     lat_cnt_d = LAT_INIT;
                  end
                  if (i_req) begin
                     starve_cnt_d = (starve_cnt_q == STARVE_MAX) ?
                                    STARVE_MAX : starve_cnt_q + SCW'(1);
                  end else begin
                     starve_cnt_d = '0;
                  end
               end else if (i_wins) begin
                  i_gnt        = 1'b1;
                  mem_addr     = i_addr;
                  addr_d       = i_addr;
                  own_data_d   = 1'b0;
                  we_d         = 1'b0;
                  state_d      = S_WAIT;
                  lat_cnt_d    = LAT_INIT;
                  starve_cnt_d = '0;
               end
            end

            S_WAIT: begin
               busy      = 1'b1;
               mem_addr  = addr_q;
               lat_cnt_d = lat_cnt_q - LCW'(1);
               if (lat_cnt_q == LAT_LAST) begin
                  state_d = S_IDLE;
                  if (own_data_q) begin
                     if (!we_q) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                     end
                  end else begin
                     i_rvalid = 1'b1;
                     i_rdata  = mem_rdata[31:0];
                  end
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and context registers; reset abandons any read in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
         addr_q       <= '0;
         own_data_q   <= 1'b0;
         we_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= addr_d;
         own_data_q   <= own_data_d;
         we_q         <= we_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share one stimulus:
// u_a (LAT=2), u_b (LAT=1), u_c (LAT=3), all with STARVE=4. Each scenario
// checks only the instance whose latency it was written for.
module tb_mem_port_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] mem_rdata;

   logic          a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_mem_wr, a_busy;
   logic [31:0]   a_i_rdata;
   logic [DW-1:0] a_d_rdata, a_mem_wdata;
   logic [AW-1:0] a_mem_addr;

   logic          b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_mem_wr, b_busy;
   logic [31:0]   b_i_rdata;
   logic [DW-1:0] b_d_rdata, b_mem_wdata;
   logic [AW-1:0] b_mem_addr;

   logic          c_i_gnt, c_i_rvalid, c_d_gnt, c_d_rvalid, c_mem_wr, c_busy;
   logic [31:0]   c_i_rdata;
   logic [DW-1:0] c_d_rdata, c_mem_wdata;
   logic [AW-1:0] c_mem_addr;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(2), .STARVE(4)) u_a (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wr(a_mem_wr), .mem_rdata(mem_rdata),
      .busy(a_busy)
   );

   mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(1), .STARVE(4)) u_b (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wr(b_mem_wr), .mem_rdata(mem_rdata),
      .busy(b_busy)
   );

   mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(3), .STARVE(4)) u_c (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(c_i_gnt), .i_rvalid(c_i_rvalid), .i_rdata(c_i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(c_d_gnt), .d_rvalid(c_d_rvalid), .d_rdata(c_d_rdata),
      .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_wr(c_mem_wr), .mem_rdata(mem_rdata),
      .busy(c_busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks run 2 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      i_req   = 1'b0;
      i_addr  = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
   endtask

   // Leaves the bench 1 unit into cycle 0, the first cycle with reset low.
   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      mem_rdata = 64'hAAAA_BBBB_1234_5678;
      idle_inputs();

      // ---------------- reset state ----------------
      do_reset();
      settle();
      check_eq("rst_busy",      64'(a_busy),     64'd0);
      check_eq("rst_i_gnt",     64'(a_i_gnt),    64'd0);
      check_eq("rst_d_gnt",     64'(a_d_gnt),    64'd0);
      check_eq("rst_mem_wr",    64'(a_mem_wr),   64'd0);
      check_eq("rst_mem_addr",  a_mem_addr,      64'd0);
      check_eq("rst_mem_wdata", a_mem_wdata,     64'd0);
      check_eq("rst_i_rvalid",  64'(a_i_rvalid), 64'd0);
      check_eq("rst_d_rvalid",  64'(a_d_rvalid), 64'd0);
      check_eq("rst_i_rdata",   64'(a_i_rdata),  64'd0);
      check_eq("rst_d_rdata",   a_d_rdata,       64'd0);
      check_eq("rst_starve",    64'(u_a.starve_cnt_q), 64'd0);
      check_eq("rst_lat",       64'(u_a.lat_cnt_q),    64'd0);

      // ---------------- single fetch, LAT=1 (u_b) ----------------
      do_reset();
      for (int c = 0; c < 5; c++) begin
         settle();
         check_eq("fetch1_pre_gnt", 64'(b_i_gnt), 64'd0);
         tick();
      end
      i_req  = 1'b1;
      i_addr = 64'h10;
      settle();
      check_eq("fetch1_gnt",      64'(b_i_gnt),  64'd1);
      check_eq("fetch1_addr",     b_mem_addr,    64'h10);
      check_eq("fetch1_busy_t",   64'(b_busy),   64'd0);
      tick();
      i_req = 1'b0;
      settle();
      check_eq("fetch1_busy",     64'(b_busy),     64'd1);
      check_eq("fetch1_rvalid",   64'(b_i_rvalid), 64'd1);
      check_eq("fetch1_rdata",    64'(b_i_rdata),  64'h1234_5678);
      check_eq("fetch1_wait_adr", b_mem_addr,      64'h10);
      tick();
      settle();
      check_eq("fetch1_idle_busy",   64'(b_busy),     64'd0);
      check_eq("fetch1_idle_rvalid", 64'(b_i_rvalid), 64'd0);
      check_eq("fetch1_idle_rdata",  64'(b_i_rdata),  64'd0);

      // ---------------- collision, LAT=2 (u_a) ----------------
      mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
      do_reset();
      i_req  = 1'b1;
      i_addr = 64'h20;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 64'h100;
      settle();
      check_eq("coll_c0_d_gnt", 64'(a_d_gnt),  64'd1);
      check_eq("coll_c0_i_gnt", 64'(a_i_gnt),  64'd0);
      check_eq("coll_c0_addr",  a_mem_addr,    64'h100);
      check_eq("coll_c0_wr",    64'(a_mem_wr), 64'd0);
      tick();
      d_req = 1'b0;
      settle();
      check_eq("coll_c1_starve", 64'(u_a.starve_cnt_q), 64'd1);
      check_eq("coll_c1_busy",   64'(a_busy),     64'd1);
      check_eq("coll_c1_i_gnt",  64'(a_i_gnt),    64'd0);
      check_eq("coll_c1_rvalid", 64'(a_d_rvalid), 64'd0);
      tick();
      settle();
      check_eq("coll_c2_d_rvalid", 64'(a_d_rvalid), 64'd1);
      check_eq("coll_c2_d_rdata",  a_d_rdata,       64'hDEAD_BEEF_CAFE_F00D);
      check_eq("coll_c2_i_rvalid", 64'(a_i_rvalid), 64'd0);
      tick();
      settle();
      check_eq("coll_c3_i_gnt", 64'(a_i_gnt), 64'd1);
      check_eq("coll_c3_addr",  a_mem_addr,   64'h20);
      tick();
      i_req = 1'b0;
      settle();
      check_eq("coll_c4_starve", 64'(u_a.starve_cnt_q), 64'd0);
      check_eq("coll_c4_busy",   64'(a_busy), 64'd1);
      tick();
      settle();
      check_eq("coll_c5_i_rvalid", 64'(a_i_rvalid), 64'd1);
      check_eq("coll_c5_i_rdata",  64'(a_i_rdata),  64'hCAFE_F00D);
      check_eq("coll_c5_d_rvalid", 64'(a_d_rvalid), 64'd0);

      // ---------------- starvation, STARVE=4 (u_a) ----------------
      do_reset();
      i_req  = 1'b1;
      i_addr = 64'h40;
      d_req  = 1'b1;
      d_we   = 1'b1;
      for (int c = 0; c < 4; c++) begin
         d_addr  = 64'h200 + 64'(8 * c);
         d_wdata = 64'(c + 1);
         settle();
         check_eq("starve_d_gnt",  64'(a_d_gnt),  64'd1);
         check_eq("starve_wr",     64'(a_mem_wr), 64'd1);
         check_eq("starve_i_gnt",  64'(a_i_gnt),  64'd0);
         check_eq("starve_wdata",  a_mem_wdata,   64'(c + 1));
         tick();
      end
      settle();
      check_eq("starve_cnt_max", 64'(u_a.starve_cnt_q), 64'd4);
      check_eq("starve_c4_i_gnt", 64'(a_i_gnt),  64'd1);
      check_eq("starve_c4_d_gnt", 64'(a_d_gnt),  64'd0);
      check_eq("starve_c4_wr",    64'(a_mem_wr), 64'd0);
      check_eq("starve_c4_addr",  a_mem_addr,    64'h40);
      tick();
      i_req = 1'b0;
      settle();
      check_eq("starve_c5_d_gnt", 64'(a_d_gnt), 64'd0);
      tick();
      settle();
      check_eq("starve_c6_i_rvalid", 64'(a_i_rvalid), 64'd1);
      check_eq("starve_c6_d_gnt",    64'(a_d_gnt),    64'd0);
      tick();
      settle();
      check_eq("starve_c7_d_gnt", 64'(a_d_gnt),  64'd1);
      check_eq("starve_c7_wr",    64'(a_mem_wr), 64'd1);
      tick();
      idle_inputs();

      // ---------------- back-to-back stores (u_a) ----------------
      do_reset();
      for (int k = 0; k < 8; k++) begin
         d_req   = 1'b1;
         d_we    = 1'b1;
         d_addr  = 64'(8 * k);
         d_wdata = 64'hC0DE_0000_0000_0000 | 64'(k);
         settle();
         check_eq("b2b_d_gnt", 64'(a_d_gnt),  64'd1);
         check_eq("b2b_wr",    64'(a_mem_wr), 64'd1);
         check_eq("b2b_addr",  a_mem_addr,    64'(8 * k));
         check_eq("b2b_wdata", a_mem_wdata,   64'hC0DE_0000_0000_0000 | 64'(k));
         check_eq("b2b_busy",  64'(a_busy),   64'd0);
         tick();
      end
      idle_inputs();
      settle();
      check_eq("b2b_after_busy", 64'(a_busy),   64'd0);
      check_eq("b2b_after_wr",   64'(a_mem_wr), 64'd0);

      // ---------------- reset mid-read, LAT=3 (u_c) ----------------
      do_reset();
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 64'h300;
      settle();
      check_eq("rmid_t_d_gnt", 64'(c_d_gnt), 64'd1);
      tick();
      d_req = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      check_eq("rmid_t2_busy",     64'(c_busy),     64'd0);
      check_eq("rmid_t2_d_rvalid", 64'(c_d_rvalid), 64'd0);
      check_eq("rmid_t2_mem_addr", c_mem_addr,      64'd0);
      check_eq("rmid_t2_d_rdata",  c_d_rdata,       64'd0);
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 64'h308;
      d_wdata = 64'h55;
      #1;
      check_eq("rmid_t2_new_gnt",  64'(c_d_gnt),  64'd1);
      check_eq("rmid_t2_new_wr",   64'(c_mem_wr), 64'd1);
      check_eq("rmid_t2_new_addr", c_mem_addr,    64'h308);
      tick();
      idle_inputs();
      settle();
      check_eq("rmid_t3_d_rvalid", 64'(c_d_rvalid), 64'd0);
      check_eq("rmid_t3_busy",     64'(c_busy),     64'd0);

      // ---------------- request withdrawn during WAIT (u_a) ----------------
      do_reset();
      i_req   = 1'b1;
      i_addr  = 64'h80;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 64'h400;
      d_wdata = 64'h77;
      settle();
      check_eq("wd_c0_d_gnt", 64'(a_d_gnt), 64'd1);
      tick();
      d_we   = 1'b0;
      d_addr = 64'h408;
      settle();
      check_eq("wd_c1_d_gnt", 64'(a_d_gnt), 64'd1);
      tick();
      idle_inputs();
      settle();
      check_eq("wd_c2_starve", 64'(u_a.starve_cnt_q), 64'd2);
      i_req  = 1'b1;
      i_addr = 64'h80;
      #1;
      check_eq("wd_c2_i_gnt", 64'(a_i_gnt), 64'd0);
      tick();
      settle();
      check_eq("wd_c3_i_gnt",    64'(a_i_gnt),    64'd0);
      check_eq("wd_c3_d_rvalid", 64'(a_d_rvalid), 64'd1);
      i_req = 1'b0;
      tick();
      settle();
      check_eq("wd_c4_i_gnt",  64'(a_i_gnt), 64'd0);
      check_eq("wd_c4_busy",   64'(a_busy),  64'd0);
      check_eq("wd_c4_starve", 64'(u_a.starve_cnt_q), 64'd2);
      tick();
      settle();
      check_eq("wd_c5_starve", 64'(u_a.starve_cnt_q), 64'd2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
